// File: rtl/hog_bin_hist_writer.sv
// Port-B read-modify-write accumulator for the 4-bank HOG bin BRAM (per-cell 18-bin histograms).
// Optional HOG_BIN_SAT_EN: bin sums saturate on overflow instead of wrapping.
module hog_bin_hist_writer #(
  parameter int TOTAL_BIT_WIDTH = 35,
  parameter int NBINS           = 18
) (
  input  logic                       aclk,
  input  logic                       arest,
  input  logic                       frame_start,
  input  logic                       pix_valid,
  output logic                       pix_ready,
  input  logic [4:0]                 pix_cell_row,
  input  logic [4:0]                 pix_cell_col,
  input  logic [4:0]                 pix_bin,
  input  logic [TOTAL_BIT_WIDTH-1:0] pix_mag,
  input  logic                       pix_last,
  output logic [12:0]                normal_addrb_0,
  output logic [12:0]                normal_addrb_1,
  output logic [12:0]                normal_addrb_2,
  output logic [12:0]                normal_addrb_3,
  output logic [TOTAL_BIT_WIDTH-1:0] dinb_0,
  output logic [TOTAL_BIT_WIDTH-1:0] dinb_1,
  output logic [TOTAL_BIT_WIDTH-1:0] dinb_2,
  output logic [TOTAL_BIT_WIDTH-1:0] dinb_3,
  input  logic [TOTAL_BIT_WIDTH-1:0] doutb_0,
  input  logic [TOTAL_BIT_WIDTH-1:0] doutb_1,
  input  logic [TOTAL_BIT_WIDTH-1:0] doutb_2,
  input  logic [TOTAL_BIT_WIDTH-1:0] doutb_3,
  output logic                       enb_0,
  output logic                       enb_1,
  output logic                       enb_2,
  output logic                       enb_3,
  output logic                       web_0,
  output logic                       web_1,
  output logic                       web_2,
  output logic                       web_3,
  output logic                       histogram_done,
  output logic                       bin_err
);

  localparam int TBW = TOTAL_BIT_WIDTH;
  localparam logic [12:0] LAST_ADDR = 13'(NBINS * 256 - 1);
  localparam logic [4:0]  NBINS_W   = 5'(NBINS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCEPT, S_READ, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t          state, next_state;
  logic [12:0]     clr_addr, addr_r, pix_addr;
  logic [1:0]      bank_r;
  logic [TBW-1:0]  mag_r, sum_r, rd_data, sum_next;
  logic            last_r, bad_bin;
  logic [12:0]     addr_v [4];
  logic [TBW-1:0]  din_v [4];
  logic [3:0]      en_v, we_v;

  assign bad_bin  = pix_bin >= NBINS_W;
  assign pix_addr = 13'({pix_cell_row[4:1], pix_cell_col[4:1]}) * 13'(NBINS) + 13'(pix_bin);

  always_comb begin
    case (bank_r)
      2'd0:    rd_data = doutb_0;
      2'd1:    rd_data = doutb_1;
      2'd2:    rd_data = doutb_2;
      default: rd_data = doutb_3;
    endcase
  end

`ifdef HOG_BIN_SAT_EN
  logic [TBW:0] raw_sum;
  assign raw_sum  = {1'b0, rd_data} + {1'b0, mag_r};
  assign sum_next = raw_sum[TBW] ? {TBW{1'b1}} : raw_sum[TBW-1:0];
`else
  assign sum_next = rd_data + mag_r;
`endif

  always_ff @(posedge aclk or posedge arest) begin
    if (arest) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (frame_start) next_state = S_CLEAR;
      S_CLEAR:  if (clr_addr == LAST_ADDR) next_state = S_ACCEPT;
      S_ACCEPT: if (pix_valid) begin
                  if (!bad_bin)     next_state = S_READ;
                  else if (pix_last) next_state = S_DONE;
                end
      S_READ:   next_state = S_WAIT;
      S_WAIT:   next_state = S_WRITE;
      S_WRITE:  next_state = last_r ? S_DONE : S_ACCEPT;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Pixel capture, clear counter and the sum register between read and write-back.
  always_ff @(posedge aclk or posedge arest) begin
    if (arest) begin
      clr_addr <= '0;
      addr_r   <= '0;
      bank_r   <= '0;
      mag_r    <= '0;
      sum_r    <= '0;
      last_r   <= 1'b0;
      bin_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          clr_addr <= '0;
          if (frame_start) bin_err <= 1'b0;
        end
        S_CLEAR: clr_addr <= clr_addr + 13'd1;
        S_ACCEPT: if (pix_valid) begin
          if (bad_bin) begin
            bin_err <= 1'b1;
          end else begin
            bank_r <= {pix_cell_row[0], pix_cell_col[0]};
            addr_r <= pix_addr;
            mag_r  <= pix_mag;
            last_r <= pix_last;
          end
        end
        S_WAIT: sum_r <= sum_next;
        default: ;
      endcase
    end
  end

  always_comb begin
    en_v           = '0;
    we_v           = '0;
    pix_ready      = 1'b0;
    histogram_done = 1'b0;
    for (int b = 0; b < 4; b++) begin
      addr_v[b] = '0;
      din_v[b]  = '0;
    end
    case (state)
      S_CLEAR: begin
        en_v = '1;
        we_v = '1;
        for (int b = 0; b < 4; b++) addr_v[b] = clr_addr;
      end
      S_ACCEPT: pix_ready = 1'b1;
      S_READ: begin
        en_v[bank_r]   = 1'b1;
        addr_v[bank_r] = addr_r;
      end
      S_WRITE: begin
        en_v[bank_r]   = 1'b1;
        we_v[bank_r]   = 1'b1;
        addr_v[bank_r] = addr_r;
        din_v[bank_r]  = sum_r;
      end
      S_DONE: histogram_done = 1'b1;
      default: ;
    endcase
  end

  assign normal_addrb_0 = addr_v[0];
  assign normal_addrb_1 = addr_v[1];
  assign normal_addrb_2 = addr_v[2];
  assign normal_addrb_3 = addr_v[3];
  assign dinb_0 = din_v[0];
  assign dinb_1 = din_v[1];
  assign dinb_2 = din_v[2];
  assign dinb_3 = din_v[3];
  assign {enb_3, enb_2, enb_1, enb_0} = en_v;
  assign {web_3, web_2, web_1, web_0} = we_v;

endmodule
